// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for the fetch/data RAM arbiter.
package mem_pkg;
  typedef enum logic {IDLE, WAIT} arb_state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} owner_t;
  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_WORD = 4'b1111;
endpackage

// File: rtl/mem_arb_prio.sv
// mem_arb_prio: data-first grant selector with a starvation counter that forces a fetch grant.
module mem_arb_prio #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req_i,
  input  logic d_req_i,
  input  logic idle_i,
  output logic if_gnt_o,
  output logic d_gnt_o
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);
  logic [SW-1:0] starve_q, starve_d;
  always_comb begin
    if_gnt_o = idle_i && if_req_i && (!d_req_i || starve_q == LIMIT);
    d_gnt_o  = idle_i && d_req_i && !if_gnt_o;
    // a data win over a waiting fetch implies starve_q < LIMIT, so this saturates
    starve_d = if_gnt_o ? '0 : (d_gnt_o && if_req_i) ? starve_q + 1'b1 : starve_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) starve_q <= '0;
    else starve_q <= starve_d;
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous-read, byte-writable RAM between fetch and load/store.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W       = 12,
  parameter int RAM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [31:0]       if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [31:0]       if_rdata_o,
  input  logic              d_req_i,
  input  logic [31:0]       d_addr_i,
  input  logic [3:0]        d_be_i,
  input  logic [31:0]       d_wdata_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [31:0]       d_rdata_o,
  output logic              ram_en_o,
  output logic [3:0]        ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [31:0]       ram_wdata_o,
  input  logic [31:0]       ram_rdata_i
);
  localparam int CW = $clog2(RAM_LATENCY + 1);
  arb_state_t  state_q;
  owner_t      owner_q;
  logic [CW-1:0] cnt_q;
  logic        if_rvalid_q, d_rvalid_q;
  logic [31:0] if_rdata_q, d_rdata_q;
  logic        idle, rd_issue;
  logic        unused_addr;
  // gating with rst keeps every combinational output at 0 while reset is held
  assign idle = state_q == IDLE && !rst;
  assign unused_addr = ^{if_addr_i[31:ADDR_W+2], if_addr_i[1:0], d_addr_i[31:ADDR_W+2], d_addr_i[1:0]};
  mem_arb_prio #(.STARVE_LIMIT(STARVE_LIMIT)) u_prio (
    .clk      (clk),
    .rst      (rst),
    .if_req_i (if_req_i),
    .d_req_i  (d_req_i),
    .idle_i   (idle),
    .if_gnt_o (if_gnt_o),
    .d_gnt_o  (d_gnt_o)
  );
  always_comb begin
    ram_en_o    = if_gnt_o || d_gnt_o;
    ram_we_o    = d_gnt_o ? d_be_i : BE_NONE;
    ram_addr_o  = d_gnt_o ? d_addr_i[ADDR_W+1:2] : if_gnt_o ? if_addr_i[ADDR_W+1:2] : '0;
    ram_wdata_o = d_gnt_o ? d_wdata_i : '0;
    rd_issue    = if_gnt_o || (d_gnt_o && d_be_i == BE_NONE);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_NONE;
      cnt_q       <= '0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if (state_q == IDLE) begin
        if (rd_issue) begin
          state_q <= WAIT;
          owner_q <= if_gnt_o ? OWN_IF : OWN_D;
          cnt_q   <= CW'(RAM_LATENCY);
        end
      end else begin
        cnt_q <= cnt_q - 1'b1;
        // last wait cycle: ram_rdata is valid now, the pulse lands next cycle
        if (cnt_q == CW'(1)) begin
          state_q <= IDLE;
          owner_q <= OWN_NONE;
          if (owner_q == OWN_IF) begin
            if_rvalid_q <= 1'b1;
            if_rdata_q  <= ram_rdata_i;
          end
          if (owner_q == OWN_D) begin
            d_rvalid_q <= 1'b1;
            d_rdata_q  <= ram_rdata_i;
          end
        end
      end
    end
  end
  assign if_rvalid_o = if_rvalid_q;
  assign if_rdata_o  = if_rdata_q;
  assign d_rvalid_o  = d_rvalid_q;
  assign d_rdata_o   = d_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus a randomized run against a cycle-level reference model.
module tb_mem_arbiter;
  import mem_pkg::*;
  localparam int LIMIT = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic if_req = 1'b0, d_req = 1'b0;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
  logic [3:0] d_be = '0;
  logic if_gnt, if_rvalid, d_gnt, d_rvalid, ram_en;
  logic [31:0] if_rdata, d_rdata, ram_wdata, ram_rdata;
  logic [3:0] ram_we;
  logic [11:0] ram_addr;
  logic i3_req = 1'b0, d3_req = 1'b0;
  logic [31:0] i3_addr = '0, d3_addr = '0;
  logic i3_gnt, i3_rvalid, d3_gnt, d3_rvalid, ram3_en;
  logic [31:0] i3_rdata, d3_rdata, ram3_wdata, ram3_rdata;
  logic [3:0] ram3_we;
  logic [11:0] ram3_addr;
  logic [31:0] mem [4096];
  logic [31:0] p3 [3];
  logic poke_en = 1'b0;
  logic [11:0] poke_addr = '0;
  logic [31:0] poke_data = '0;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(12), .RAM_LATENCY(1), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt), .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
    .d_req_i(d_req), .d_addr_i(d_addr), .d_be_i(d_be), .d_wdata_i(d_wdata),
    .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata),
    .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
  );

  mem_arbiter #(.ADDR_W(12), .RAM_LATENCY(3), .STARVE_LIMIT(LIMIT)) u3 (
    .clk(clk), .rst(rst),
    .if_req_i(i3_req), .if_addr_i(i3_addr), .if_gnt_o(i3_gnt), .if_rvalid_o(i3_rvalid), .if_rdata_o(i3_rdata),
    .d_req_i(d3_req), .d_addr_i(d3_addr), .d_be_i(BE_NONE), .d_wdata_i(32'h0),
    .d_gnt_o(d3_gnt), .d_rvalid_o(d3_rvalid), .d_rdata_o(d3_rdata),
    .ram_en_o(ram3_en), .ram_we_o(ram3_we), .ram_addr_o(ram3_addr), .ram_wdata_o(ram3_wdata), .ram_rdata_i(ram3_rdata)
  );

  always @(posedge clk) begin
    if (poke_en) mem[poke_addr] <= poke_data;
    else if (ram_en) begin
      for (int b = 0; b < 4; b++) if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      ram_rdata <= mem[ram_addr];
    end
  end

  always @(posedge clk) begin
    p3[0] <= ram3_en ? {20'hC0DE0, ram3_addr} : 32'h0;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign ram3_rdata = p3[2];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [11:0] a, input logic [31:0] d);
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    tick();
    poke_en = 1'b0;
  endtask

  function automatic logic [31:0] mkaddr(input int idx);
    return ($urandom & 32'hFFFF_C003) | (32'(idx) << 2);
  endfunction

  task automatic test_reset;
    if_req = 1'b1; d_req = 1'b1; if_addr = 32'h14; d_addr = 32'h8; d_be = 4'hF; d_wdata = 32'hFFFF_FFFF;
    #3;
    checks++; if ({if_gnt, d_gnt, ram_en, ram_we} !== 7'b0) begin errors++; $display("FAIL reset_gnt got %b exp 0", {if_gnt, d_gnt, ram_en, ram_we}); end
    checks++; if ({ram_addr, ram_wdata} !== 44'b0) begin errors++; $display("FAIL reset_ram got %h exp 0", {ram_addr, ram_wdata}); end
    checks++; if ({if_rvalid, d_rvalid, if_rdata, d_rdata} !== 66'b0) begin errors++; $display("FAIL reset_rd got %h exp 0", {if_rvalid, d_rvalid, if_rdata, d_rdata}); end
    if_req = 1'b0; d_req = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_single_fetch;
    poke(12'd5, 32'hDEADBEEF);
    if_req = 1'b1; if_addr = 32'h14;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++; if (if_gnt !== (c == 0)) begin errors++; $display("FAIL fetch_gnt c%0d got %b exp %b", c, if_gnt, c == 0); end
      if (c == 0) begin
        checks++; if ({ram_en, ram_we, ram_addr} !== {1'b1, 4'b0, 12'd5}) begin errors++; $display("FAIL fetch_issue got %h", {ram_en, ram_we, ram_addr}); end
      end
      checks++; if (if_rvalid !== (c == 2) || d_rvalid !== 1'b0) begin errors++; $display("FAIL fetch_rvalid c%0d got %b%b", c, if_rvalid, d_rvalid); end
      if (c >= 2) begin
        checks++; if (if_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL fetch_rdata got %h exp deadbeef", if_rdata); end
      end
      tick();
      if_req = 1'b0;
    end
  endtask

  task automatic test_store_load;
    poke(12'd2, 32'h11223344);
    d_req = 1'b1; d_addr = 32'h8; d_be = 4'b0010; d_wdata = 32'h0000AB00;
    @(negedge clk);
    checks++; if ({d_gnt, ram_en, ram_we, ram_addr, ram_wdata} !== {1'b1, 1'b1, 4'b0010, 12'd2, 32'h0000AB00}) begin
      errors++; $display("FAIL store_issue got %h", {d_gnt, ram_en, ram_we, ram_addr, ram_wdata}); end
    tick();
    d_be = BE_NONE;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (d_gnt !== (c == 0)) begin errors++; $display("FAIL load_gnt c%0d got %b exp %b", c, d_gnt, c == 0); end
      checks++; if (d_rvalid !== (c == 2)) begin errors++; $display("FAIL load_rvalid c%0d got %b exp %b", c, d_rvalid, c == 2); end
      tick();
      d_req = 1'b0;
    end
    checks++; if (d_rdata !== 32'h1122AB44) begin errors++; $display("FAIL load_rdata got %h exp 1122ab44", d_rdata); end
  endtask

  task automatic test_contention;
    if_req = 1'b1; if_addr = 32'h30; d_req = 1'b1; d_addr = 32'h190; d_be = BE_WORD;
    for (int c = 0; c <= 10; c++) begin
      d_wdata = 32'(c);
      @(negedge clk);
      checks++; if (if_gnt !== (c == 4 || c == 10)) begin errors++; $display("FAIL cont_if c%0d got %b", c, if_gnt); end
      checks++; if (d_gnt !== !(c == 4 || c == 5 || c == 10)) begin errors++; $display("FAIL cont_d c%0d got %b", c, d_gnt); end
      checks++; if (if_rvalid !== (c == 6) || d_rvalid !== 1'b0) begin errors++; $display("FAIL cont_rvalid c%0d got %b%b", c, if_rvalid, d_rvalid); end
      tick();
    end
    if_req = 1'b0; d_req = 1'b0;
    tick(); tick();
  endtask

  task automatic test_simul_reads;
    poke(12'd7, 32'hA5A50007);
    poke(12'd9, 32'h09099999);
    if_req = 1'b1; if_addr = 32'h24; d_req = 1'b1; d_addr = 32'h1C; d_be = BE_NONE;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if (d_gnt !== (c == 0) || if_gnt !== (c == 2)) begin errors++; $display("FAIL simul_gnt c%0d got d%b i%b", c, d_gnt, if_gnt); end
      checks++; if (d_rvalid !== (c == 2) || if_rvalid !== (c == 4)) begin errors++; $display("FAIL simul_rvalid c%0d got d%b i%b", c, d_rvalid, if_rvalid); end
      if (c == 2) begin
        checks++; if (d_rdata !== 32'hA5A50007) begin errors++; $display("FAIL simul_drdata got %h exp a5a50007", d_rdata); end
      end
      if (c == 4) begin
        checks++; if (if_rdata !== 32'h09099999) begin errors++; $display("FAIL simul_ifrdata got %h exp 09099999", if_rdata); end
      end
      tick();
      if (c == 0) d_req = 1'b0;
      if (c == 2) if_req = 1'b0;
    end
  endtask

  task automatic test_reset_midread;
    if_req = 1'b1; if_addr = 32'h24;
    @(negedge clk);
    checks++; if (if_gnt !== 1'b1) begin errors++; $display("FAIL midrst_gnt got %b exp 1", if_gnt); end
    tick();
    if_req = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++; if ({if_gnt, d_gnt, ram_en, ram_we, ram_addr, ram_wdata} !== 50'b0) begin errors++; $display("FAIL midrst_ram got %h exp 0", {ram_en, ram_we, ram_addr, ram_wdata}); end
    checks++; if ({if_rvalid, d_rvalid, if_rdata, d_rdata} !== 66'b0) begin errors++; $display("FAIL midrst_rd got %h exp 0", {if_rvalid, if_rdata, d_rdata}); end
    tick();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (if_rvalid !== 1'b0) begin errors++; $display("FAIL midrst_stale c%0d got %b exp 0", c, if_rvalid); end
      tick();
    end
    if_req = 1'b1; if_addr = 32'h14;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (if_gnt !== (c == 0) || if_rvalid !== (c == 2)) begin errors++; $display("FAIL midrst_fresh c%0d got g%b v%b", c, if_gnt, if_rvalid); end
      tick();
      if_req = 1'b0;
    end
    checks++; if (if_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL midrst_rdata got %h exp deadbeef", if_rdata); end
  endtask

  task automatic test_latency3;
    i3_req = 1'b1; i3_addr = 32'h40;
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      checks++; if (i3_gnt !== (c == 0) || d3_gnt !== (c == 4)) begin errors++; $display("FAIL lat3_gnt c%0d got i%b d%b", c, i3_gnt, d3_gnt); end
      checks++; if (i3_rvalid !== (c == 4) || d3_rvalid !== (c == 8)) begin errors++; $display("FAIL lat3_rvalid c%0d got i%b d%b", c, i3_rvalid, d3_rvalid); end
      if (c == 4) begin
        checks++; if (i3_rdata !== 32'hC0DE0010) begin errors++; $display("FAIL lat3_irdata got %h exp c0de0010", i3_rdata); end
      end
      if (c == 8) begin
        checks++; if (d3_rdata !== 32'hC0DE0011) begin errors++; $display("FAIL lat3_drdata got %h exp c0de0011", d3_rdata); end
      end
      tick();
      if (c == 0) begin i3_req = 1'b0; d3_req = 1'b1; d3_addr = 32'h44; end
      if (c == 4) d3_req = 1'b0;
    end
  endtask

  task automatic test_random;
    logic [31:0] m_mem [16];
    logic [31:0] val_if = '0, val_d = '0, exp_if = '0, exp_d = '0;
    int wait_c = 0, starve = 0, due_if = -1, due_d = -1;
    logic eif, ed;
    logic [3:0] wi, wd;
    for (int w = 0; w < 16; w++) begin
      m_mem[w] = $urandom;
      poke(12'(w), m_mem[w]);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!if_req && $urandom_range(0, 2) == 0) begin if_req = 1'b1; if_addr = mkaddr($urandom_range(0, 15)); end
      if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req = 1'b1; d_addr = mkaddr($urandom_range(0, 15)); d_wdata = $urandom;
        d_be = $urandom_range(0, 1) ? BE_NONE : 4'($urandom);
      end
      wi = if_addr[5:2]; wd = d_addr[5:2];
      @(negedge clk);
      eif = wait_c == 0 && if_req && (!d_req || starve == LIMIT);
      ed  = wait_c == 0 && d_req && !eif;
      if (due_if == c) exp_if = val_if;
      if (due_d == c) exp_d = val_d;
      checks++; if (if_gnt !== eif || d_gnt !== ed) begin errors++; $display("FAIL rnd_gnt c%0d got i%b d%b exp i%b d%b", c, if_gnt, d_gnt, eif, ed); end
      checks++; if (if_rvalid !== (due_if == c) || d_rvalid !== (due_d == c)) begin errors++; $display("FAIL rnd_rvalid c%0d got i%b d%b", c, if_rvalid, d_rvalid); end
      checks++; if (if_rdata !== exp_if || d_rdata !== exp_d) begin errors++; $display("FAIL rnd_rdata c%0d got %h %h exp %h %h", c, if_rdata, d_rdata, exp_if, exp_d); end
      checks++; if ({ram_en, ram_we, ram_addr} !== {eif || ed, ed ? d_be : 4'b0, eif ? 12'(wi) : ed ? 12'(wd) : 12'd0}) begin
        errors++; $display("FAIL rnd_ram c%0d got %h", c, {ram_en, ram_we, ram_addr}); end
      if (wait_c > 0) wait_c--;
      if (eif) begin
        starve = 0; val_if = m_mem[wi]; due_if = c + 2; wait_c = 1;
      end else if (ed) begin
        if (if_req) starve++;
        if (d_be == BE_NONE) begin val_d = m_mem[wd]; due_d = c + 2; wait_c = 1; end
        else for (int b = 0; b < 4; b++) if (d_be[b]) m_mem[wd][8*b +: 8] = d_wdata[8*b +: 8];
      end
      tick();
      if (eif) if_req = 1'b0;
      if (ed) d_req = 1'b0;
    end
    if_req = 1'b0; d_req = 1'b0;
    tick(); tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_fetch();
    test_store_load();
    test_contention();
    test_simul_reads();
    test_reset_midread();
    test_latency3();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
